// File: rtl/register_bank_pkg.sv
// Shared types and constants for the register bank: FSM state, default widths, ABI register indices.
package register_bank_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned ZR = 0;
  localparam int unsigned AT = 1;
  localparam int unsigned V0 = 2;
  localparam int unsigned V1 = 3;
  localparam int unsigned A0 = 4;
  localparam int unsigned A1 = 5;
  localparam int unsigned A2 = 6;
  localparam int unsigned A3 = 7;
  localparam int unsigned T0 = 8;
  localparam int unsigned T1 = 9;
  localparam int unsigned T2 = 10;
  localparam int unsigned T3 = 11;
  localparam int unsigned T4 = 12;
  localparam int unsigned T5 = 13;
  localparam int unsigned T6 = 14;
  localparam int unsigned T7 = 15;
  localparam int unsigned S0 = 16;
  localparam int unsigned S1 = 17;
  localparam int unsigned S2 = 18;
  localparam int unsigned S3 = 19;
  localparam int unsigned S4 = 20;
  localparam int unsigned S5 = 21;
  localparam int unsigned S6 = 22;
  localparam int unsigned S7 = 23;
  localparam int unsigned T8 = 24;
  localparam int unsigned T9 = 25;
  localparam int unsigned K0 = 26;
  localparam int unsigned K1 = 27;
  localparam int unsigned GP = 28;
  localparam int unsigned SP = 29;
  localparam int unsigned FP = 30;
  localparam int unsigned RA = 31;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy bits for hazard detection: set on reserve, cleared on writeback.
// REGISTER_BANK_BYPASS_EN: a same-cycle writeback clears the looked-up busy flag early.
module register_scoreboard
  import register_bank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic                  busy1_c,
  output logic                  busy2_c
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             set_v, clr_v;

  // Reserve is applied after release so a new producer wins over a same-cycle writeback
  always_comb begin
    set_v  = set_en && (set_addr != '0);
    clr_v  = clr_en && (clr_addr != '0);
    busy_d = busy_q;
    if (clr_v) busy_d[clr_addr] = 1'b0;
    if (set_v) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy1_c = busy_q[rd_addr1];
    busy2_c = busy_q[rd_addr2];
`ifdef REGISTER_BANK_BYPASS_EN
    if (clr_v && (clr_addr == rd_addr1)) busy1_c = set_v && (set_addr == rd_addr1);
    if (clr_v && (clr_addr == rd_addr2)) busy2_c = set_v && (set_addr == rd_addr2);
`endif
  end

endmodule

// File: rtl/register_bank.sv
// Register file with one write port, two combinational read ports, busy scoreboard and a
// post-reset init sweep seeding reg[i] = i. REGISTER_BANK_BYPASS_EN forwards writeData to reads.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] register1,
  input  logic [ADDR_WIDTH-1:0] register2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserveRegister,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  ready
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic                    in_ready;
  logic                    wr_v;

  assign in_ready = (state_q == READY);
  assign wr_v     = in_ready && regWrite && (writeRegister != '0);
  assign ready    = in_ready;

  // Init sweep and array update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    unique case (state_q)
      INIT: begin
        mem_d[cnt_q] = DATA_WIDTH'(cnt_q);
        cnt_d        = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (wr_v) mem_d[writeRegister] = writeData;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array contents are rewritten by the sweep after every reset, so no reset here
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (in_ready && (register1 != '0)) begin
      readData1 = mem_q[register1];
`ifdef REGISTER_BANK_BYPASS_EN
      if (wr_v && (register1 == writeRegister)) readData1 = writeData;
`endif
    end
    if (in_ready && (register2 != '0)) begin
      readData2 = mem_q[register2];
`ifdef REGISTER_BANK_BYPASS_EN
      if (wr_v && (register2 == writeRegister)) readData2 = writeData;
`endif
    end
  end

  logic sb_busy1, sb_busy2;

  register_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (in_ready && reserve),
    .set_addr (reserveRegister),
    .clr_en   (in_ready && regWrite),
    .clr_addr (writeRegister),
    .rd_addr1 (register1),
    .rd_addr2 (register2),
    .busy1_c  (sb_busy1),
    .busy2_c  (sb_busy2)
  );

  assign busy1 = in_ready && sb_busy1;
  assign busy2 = in_ready && sb_busy2;

endmodule
